// File: rtl/debounce_multi_if.sv
// Button-conditioner bus: raw levels and control in, filtered levels and event pulses out.
// The master side drives the buttons and ticks; the slave side is the conditioner.
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] buttons;
  logic                sample_en;
  logic [CHANNELS-1:0] repeat_en;
  logic [CHANNELS-1:0] debounced;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] released;

  modport master (
    output buttons, sample_en, repeat_en,
    input  debounced, pressed, released
  );

  modport slave (
    input  buttons, sample_en, repeat_en,
    output debounced, pressed, released
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, tick-based stability filter,
// registered press/release pulses and optional auto-repeat; no backpressure, every event pulses once.
module debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 4,
  parameter int REPEAT_DELAY = 6,
  parameter int REPEAT_RATE  = 3
) (
  input logic              clk,
  input logic              reset,
  debounce_multi_if.slave  bus
);

  localparam int SW       = $clog2(STABLE_COUNT + 1);
  localparam int RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW       = $clog2(RPT_MAX + 1);

  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } rpt_phase_t;

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (STABLE_COUNT < 1) begin : g_bad_stable
    $error("debounce_multi: STABLE_COUNT must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("debounce_multi: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rate
    $error("debounce_multi: REPEAT_RATE must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SW-1:0]          stab_cnt;
    logic [RW-1:0]          rpt_cnt;
    rpt_phase_t             phase;
    logic                   deb_q;
    logic                   press_q;
    logic                   rel_q;

    logic                   synced;
    logic                   flip;
    logic                   rise;
    logic                   fall;
    logic                   rpt_active;
    logic                   rpt_hit;
    logic [RW-1:0]          rpt_next;
    logic [RW-1:0]          rpt_thresh;

    always_comb begin
      synced     = sync_q[SYNC_STAGES-1];
      flip       = bus.sample_en && (synced != deb_q) &&
                   (stab_cnt == SW'(STABLE_COUNT - 1));
      rise       = flip && !deb_q;
      fall       = flip && deb_q;
      rpt_active = deb_q && bus.repeat_en[i];
      rpt_next   = rpt_cnt + RW'(1);
      rpt_thresh = (phase == PH_RATE) ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
      // A falling edge ends the hold, so it never doubles as a repeat event.
      rpt_hit    = bus.sample_en && rpt_active && !fall && (rpt_next == rpt_thresh);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q   <= '0;
        stab_cnt <= '0;
        rpt_cnt  <= '0;
        phase    <= PH_DELAY;
        deb_q    <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.buttons[i]};

        if (bus.sample_en) begin
          if (synced == deb_q) begin
            stab_cnt <= '0;
          end else if (flip) begin
            stab_cnt <= '0;
            deb_q    <= ~deb_q;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end

        press_q <= rise | rpt_hit;
        rel_q   <= fall;

        if (rise || fall || !rpt_active) begin
          rpt_cnt <= '0;
          phase   <= PH_DELAY;
        end else if (bus.sample_en) begin
          if (rpt_hit) begin
            rpt_cnt <= '0;
            phase   <= PH_RATE;
          end else begin
            rpt_cnt <= rpt_next;
          end
        end
      end
    end

    assign bus.debounced[i] = deb_q;
    assign bus.pressed[i]   = press_q;
    assign bus.released[i]  = rel_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with default parameters; edge k counts posedges after a stimulus step.
module tb_debounce_multi;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  debounce_multi_if #(.CHANNELS(4)) bus ();

  debounce_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .STABLE_COUNT(4), .REPEAT_DELAY(6), .REPEAT_RATE(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.buttons   = 4'h0;
    bus.repeat_en = 4'h0;
    bus.sample_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] got, exp;
    bus.buttons   = 4'hF;
    bus.sample_en = 1'b1;
    bus.repeat_en = 4'h0;
    reset         = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      got = {bus.debounced, bus.pressed, bus.released};
      checks++;
      if (got !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=000", k, got);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      got = {bus.debounced, bus.pressed, bus.released};
      exp = {(k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_release edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [11:0] got, exp;
    do_reset();
    bus.buttons = 4'b0001;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      got = {bus.debounced, bus.pressed, bus.released};
      exp = {(k >= 6 && k < 26) ? 4'b0001 : 4'b0000,
             (k == 6)  ? 4'b0001 : 4'b0000,
             (k == 26) ? 4'b0001 : 4'b0000};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_press edge=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 20) bus.buttons = 4'b0000;
    end
  endtask

  task automatic test_glitch();
    logic [11:0] got, exp;
    do_reset();
    bus.buttons = 4'b0010;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      got = {bus.debounced, bus.pressed, bus.released};
      exp = {(k >= 36) ? 4'b0010 : 4'b0000, (k == 36) ? 4'b0010 : 4'b0000, 4'b0000};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch edge=%0d got=%h exp=%h", k, got, exp);
      end
      bus.buttons = (k >= 30 || ((k / 3) % 2) == 0) ? 4'b0010 : 4'b0000;
    end
  endtask

  task automatic test_repeat(input logic en);
    logic [11:0] got, exp;
    logic        rpt;
    do_reset();
    bus.repeat_en = {1'b0, en, 2'b00};
    bus.buttons   = 4'b0100;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      rpt = en && (k >= 12) && (k <= 27) && (((k - 12) % 3) == 0);
      got = {bus.debounced, bus.pressed, bus.released};
      exp = {(k >= 6 && k < 29) ? 4'b0100 : 4'b0000,
             (k == 6 || rpt) ? 4'b0100 : 4'b0000,
             (k == 29) ? 4'b0100 : 4'b0000};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL repeat en=%0d edge=%0d got=%h exp=%h", en, k, got, exp);
      end
      if (k == 23) bus.buttons = 4'b0000;
    end
    bus.repeat_en = 4'h0;
  endtask

  task automatic test_sample_en();
    logic [11:0] got, exp;
    do_reset();
    bus.buttons   = 4'b1000;
    bus.sample_en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      got = {bus.debounced, bus.pressed, bus.released};
      exp = {(k >= 16) ? 4'b1000 : 4'b0000, (k == 16) ? 4'b1000 : 4'b0000, 4'b0000};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sample_en edge=%0d got=%h exp=%h", k, got, exp);
      end
      bus.sample_en = (((k + 1) % 4) == 0);
    end
    bus.sample_en = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    logic [11:0] got, exp;
    @(negedge clk);
    checks++;
    if (bus.debounced !== 4'b1000) begin
      errors++;
      $display("FAIL pre_reset_level got=%h exp=8", bus.debounced);
    end
    reset = 1'b1;
    #1;
    got = {bus.debounced, bus.pressed, bus.released};
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL reset_async got=%h exp=000", got);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = {bus.debounced, bus.pressed, bus.released};
      checks++;
      if (got !== 12'h000) begin
        errors++;
        $display("FAIL reset_no_release cyc=%0d got=%h exp=000", k, got);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      got = {bus.debounced, bus.pressed, bus.released};
      exp = {(k >= 6) ? 4'b1000 : 4'b0000, (k == 6) ? 4'b1000 : 4'b0000, 4'b0000};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_rehold edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  initial begin
    bus.buttons   = 4'h0;
    bus.sample_en = 1'b1;
    bus.repeat_en = 4'h0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_repeat(1'b1);
    test_repeat(1'b0);
    test_sample_en();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
